// File: rtl/router_pkg.sv
// Shared router definitions: port indices, crossbar select encoding and
// small helpers used by the switch allocator.
package router_pkg;

  localparam int NP = 5;

  localparam int P_LOCAL = 0;
  localparam int P_N     = 1;
  localparam int P_E     = 2;
  localparam int P_S     = 3;
  localparam int P_W     = 4;

  typedef logic [NP-1:0] sel_t;
  typedef logic [2:0]    ptr_t;

  localparam sel_t SEL_IDLE = 5'b00000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_st_t;

  function automatic logic is_onehot(input sel_t v);
    return (v != SEL_IDLE) && ((v & (v - 5'd1)) == SEL_IDLE);
  endfunction

  // Pointer value just past the one-hot winner, wrapping at NP.
  function automatic ptr_t next_ptr(input sel_t onehot);
    ptr_t r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      if (onehot[i]) r = (i == NP - 1) ? ptr_t'(0) : ptr_t'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Combinational 5-way round-robin arbiter: the first request at or above
// ptr_i (modulo 5) wins.
module rr_arb5
  import router_pkg::*;
(
  input  sel_t req_i,
  input  ptr_t ptr_i,
  output sel_t gnt_o,
  output logic any_o
);

  ptr_t idx;
  logic found;

  always_comb begin
    gnt_o = SEL_IDLE;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NP; i++) begin
      idx = ptr_t'((int'(ptr_i) + i) % NP);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/switch_alloc_r20.sv
// Wormhole switch allocator: per-output round-robin arbitration with a lock
// held from grant until the owning input's tail flit transfers.
module switch_alloc_r20
  import router_pkg::*;
#(
  parameter int NP = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req0,
  input  logic [4:0] req1,
  input  logic [4:0] req2,
  input  logic [4:0] req3,
  input  logic [4:0] req4,
  input  logic       vld0,
  input  logic       vld1,
  input  logic       vld2,
  input  logic       vld3,
  input  logic       vld4,
  input  logic       tail0,
  input  logic       tail1,
  input  logic       tail2,
  input  logic       tail3,
  input  logic       tail4,
  output logic [4:0] sel0,
  output logic [4:0] sel1,
  output logic [4:0] sel2,
  output logic [4:0] sel3,
  output logic [4:0] sel4,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt4,
  output logic       ovld0,
  output logic       ovld1,
  output logic       ovld2,
  output logic       ovld3,
  output logic       ovld4
);

  sel_t          req_a [NP];
  logic [NP-1:0] vld_v, tail_v;

  assign req_a[P_LOCAL] = req0;
  assign req_a[P_N]     = req1;
  assign req_a[P_E]     = req2;
  assign req_a[P_S]     = req3;
  assign req_a[P_W]     = req4;
  assign vld_v  = {vld4, vld3, vld2, vld1, vld0};
  assign tail_v = {tail4, tail3, tail2, tail1, tail0};

  out_st_t       st_q  [NP];
  out_st_t       st_d  [NP];
  sel_t          sel_q [NP];
  sel_t          sel_d [NP];
  ptr_t          ptr_q [NP];
  ptr_t          ptr_d [NP];
  logic [NP-1:0] ovld_q, ovld_d, gnt_q, gnt_d;

  logic [NP-1:0][NP-1:0] cand;
  sel_t                  arb_gnt [NP];
  logic [NP-1:0]         arb_any;

  // An input competes only with an exactly one-hot request and while it owns nothing.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_out
      for (gk = 0; gk < NP; gk++) begin : g_in
        assign cand[gi][gk] = req_a[gk][gi] & is_onehot(req_a[gk]) & ~gnt_q[gk];
      end
      rr_arb5 u_arb (
        .req_i (cand[gi]),
        .ptr_i (ptr_q[gi]),
        .gnt_o (arb_gnt[gi]),
        .any_o (arb_any[gi])
      );
    end
  endgenerate

  always_comb begin
    gnt_d  = '0;
    ovld_d = '0;
    for (int j = 0; j < NP; j++) begin
      st_d[j]   = st_q[j];
      sel_d[j]  = sel_q[j];
      ptr_d[j]  = ptr_q[j];
      ovld_d[j] = |(sel_q[j] & vld_v);
      case (st_q[j])
        ST_IDLE: begin
          if (arb_any[j]) begin
            st_d[j]  = ST_LOCKED;
            sel_d[j] = arb_gnt[j];
            ptr_d[j] = next_ptr(arb_gnt[j]);
          end
        end
        ST_LOCKED: begin
          if (|(sel_q[j] & vld_v & tail_v)) begin
            st_d[j]  = ST_IDLE;
            sel_d[j] = SEL_IDLE;
          end
        end
        default: begin
          st_d[j]  = ST_IDLE;
          sel_d[j] = SEL_IDLE;
        end
      endcase
      gnt_d = gnt_d | sel_d[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NP; j++) begin
        st_q[j]  <= ST_IDLE;
        sel_q[j] <= SEL_IDLE;
        ptr_q[j] <= '0;
      end
      ovld_q <= '0;
      gnt_q  <= '0;
    end else begin
      for (int j = 0; j < NP; j++) begin
        st_q[j]  <= st_d[j];
        sel_q[j] <= sel_d[j];
        ptr_q[j] <= ptr_d[j];
      end
      ovld_q <= ovld_d;
      gnt_q  <= gnt_d;
    end
  end

  assign sel0  = sel_q[P_LOCAL];
  assign sel1  = sel_q[P_N];
  assign sel2  = sel_q[P_E];
  assign sel3  = sel_q[P_S];
  assign sel4  = sel_q[P_W];
  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign gnt2  = gnt_q[2];
  assign gnt3  = gnt_q[3];
  assign gnt4  = gnt_q[4];
  assign ovld0 = ovld_q[0];
  assign ovld1 = ovld_q[1];
  assign ovld2 = ovld_q[2];
  assign ovld3 = ovld_q[3];
  assign ovld4 = ovld_q[4];

endmodule

// File: tb/tb_switch_alloc_r20.sv
// Self-checking bench for switch_alloc_r20: a reference model pushes the
// expected registered outputs per cycle, compared one cycle later.
module tb_switch_alloc_r20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] req [5];
  logic [4:0] vld, tail;
  logic [4:0] sel [5];
  logic [4:0] gnt, ovld;

  switch_alloc_r20 dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]), .req4(req[4]),
    .vld0(vld[0]), .vld1(vld[1]), .vld2(vld[2]), .vld3(vld[3]), .vld4(vld[4]),
    .tail0(tail[0]), .tail1(tail[1]), .tail2(tail[2]), .tail3(tail[3]), .tail4(tail[4]),
    .sel0(sel[0]), .sel1(sel[1]), .sel2(sel[2]), .sel3(sel[3]), .sel4(sel[4]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]), .gnt4(gnt[4]),
    .ovld0(ovld[0]), .ovld1(ovld[1]), .ovld2(ovld[2]), .ovld3(ovld[3]), .ovld4(ovld[4])
  );

  typedef struct packed {
    logic [24:0] sel;
    logic [4:0]  gnt;
    logic [4:0]  ovld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state and per-input packet sources.
  int own  [5] = '{-1, -1, -1, -1, -1};
  int ptr  [5] = '{0, 0, 0, 0, 0};
  int len  [5] = '{0, 0, 0, 0, 0};
  int plen [5] = '{0, 0, 0, 0, 0};
  bit hold [5] = '{0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b exp %b", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    int   nown [5];
    bit   busy [5];
    bit   xfer [5];
    exp_t o;
    for (int k = 0; k < 5; k++) begin
      tail[k] = (len[k] == 1);
      busy[k] = 1'b0;
      xfer[k] = 1'b0;
    end
    e = '0;
    if (rst) begin
      for (int j = 0; j < 5; j++) begin
        own[j] = -1;
        ptr[j] = 0;
      end
    end else begin
      for (int j = 0; j < 5; j++) if (own[j] >= 0) busy[own[j]] = 1'b1;
      for (int j = 0; j < 5; j++) begin
        nown[j] = own[j];
        if (own[j] >= 0) begin
          if (vld[own[j]]) begin
            e.ovld[j] = 1'b1;
            xfer[own[j]] = 1'b1;
            if (tail[own[j]]) nown[j] = -1;
          end
        end else begin
          for (int i = 0; i < 5; i++) begin
            int k;
            k = (ptr[j] + i) % 5;
            if (nown[j] < 0 && !busy[k] && req[k] == 5'(1 << j)) begin
              nown[j] = k;
              ptr[j]  = (k + 1) % 5;
            end
          end
        end
      end
      for (int j = 0; j < 5; j++) own[j] = nown[j];
    end
    for (int j = 0; j < 5; j++) begin
      if (own[j] >= 0) begin
        e.sel[j*5 +: 5] = 5'(1 << own[j]);
        e.gnt[own[j]]   = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = exp_q.pop_front();
    for (int j = 0; j < 5; j++) chk($sformatf("sel%0d", j), sel[j], o.sel[j*5 +: 5]);
    chk("gnt", gnt, o.gnt);
    chk("ovld", ovld, o.ovld);
    for (int k = 0; k < 5; k++) begin
      if (xfer[k]) begin
        len[k]--;
        if (len[k] == 0) begin
          if (hold[k]) len[k] = plen[k];
          else req[k] = 5'b00000;
        end
      end
    end
  endtask

  task automatic start(input int k, input logic [4:0] r, input int n, input bit h);
    req[k]  = r;
    plen[k] = n;
    len[k]  = n;
    hold[k] = h;
    vld[k]  = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 5; k++) hold[k] = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    vld = '0;
    for (int i = 0; i < 2; i++) cycle();
  endtask

  logic [4:0] order [4] = '{5'b00001, 5'b01000, 5'b10000, 5'b00001};
  logic [4:0] got_q[$];
  int         n_sel, n_ovld;

  initial begin
    rst = 1'b1;
    vld = '0;
    tail = '0;
    for (int k = 0; k < 5; k++) req[k] = 5'b00000;

    // Reset with every input requesting output 0.
    for (int k = 0; k < 5; k++) start(k, 5'b00001, 1, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_first_grant", sel[0], 5'b00001);
    cycle();
    cycle();
    drain();

    // Single 3-flit packet from input 1 to output 2.
    start(1, 5'b00100, 3, 1'b0);
    n_sel = 0;
    n_ovld = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) chk("single_first", sel[2], 5'b00010);
      if (sel[2] == 5'b00010) n_sel++;
      if (ovld[2]) n_ovld++;
    end
    chk("single_sel_cycles", 5'(n_sel), 5'd3);
    chk("single_ovld_cycles", 5'(n_ovld), 5'd3);
    drain();

    // Contention on output 1 from inputs 0, 3, 4.
    start(0, 5'b00010, 1, 1'b1);
    start(3, 5'b00010, 1, 1'b1);
    start(4, 5'b00010, 1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (sel[1] != 5'b00000) got_q.push_back(sel[1]);
    end
    chk("cont_count", 5'(got_q.size() >= 4), 5'd1);
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("cont_order", got_q[i], order[i]);
    drain();

    // 4-flit packet on input 2 -> output 3 with a 2-cycle stall.
    start(2, 5'b01000, 4, 1'b0);
    cycle();
    cycle();
    cycle();
    vld[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_sel", sel[3], 5'b00100);
      chk("stall_ovld", {4'b0, ovld[3]}, 5'd0);
    end
    vld[2] = 1'b1;
    cycle();
    chk("stall_hold", sel[3], 5'b00100);
    cycle();
    chk("stall_release", sel[3], 5'b00000);
    drain();

    // Parallel grants and a multi-hot request that must be ignored.
    start(0, 5'b00010, 2, 1'b0);
    start(2, 5'b01000, 2, 1'b0);
    start(4, 5'b00011, 2, 1'b0);
    cycle();
    chk("par_sel1", sel[1], 5'b00001);
    chk("par_sel3", sel[3], 5'b00100);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("par_no_gnt4", {4'b0, gnt[4]}, 5'd0);
    end
    req[4] = 5'b00000;
    len[4] = 0;
    vld[4] = 1'b0;
    drain();

    // Reset during flit 2 of a 4-flit packet.
    start(1, 5'b00100, 4, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rstmid_sel2", sel[2], 5'b00000);
    chk("rstmid_gnt", gnt, 5'b00000);
    rst = 1'b0;
    req[1] = 5'b00000;
    len[1] = 0;
    vld[1] = 1'b0;
    cycle();
    start(0, 5'b00100, 1, 1'b0);
    start(1, 5'b00100, 1, 1'b0);
    cycle();
    chk("rstmid_ptr", sel[2], 5'b00001);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
